// File: rtl/score_pkg.sv
// score_pkg: types and constants shared by the round controller and the scoring stage.
//   state_e   - round controller FSM states
//   ID_W      - player ID width (scoring RAM address width)
//   SCORE_W   - score width
//   MAX_SCORE - score saturation ceiling (two valid BCD digits)
//   GUEST_ID  - guest login ID; scoring reports pwinner=0 for it
//   sat_inc   - saturating score increment
package score_pkg;

   localparam int unsigned ID_W      = 5;
   localparam int unsigned SCORE_W   = 7;
   localparam int unsigned MAX_SCORE = 99;
   localparam int unsigned GUEST_ID  = 3;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PLAY      = 3'd1,
      REQ       = 3'd2,
      WAIT_RESP = 3'd3,
      RESULT    = 3'd4
   } state_e;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s >= SCORE_W'(MAX_SCORE)) ? s : s + 1'b1;
   endfunction

endpackage

// File: rtl/round_timer.sv
// round_timer: per-round seconds countdown.
//   clk, rst  - clock, synchronous active-low reset
//   load      - reload secs_left with ROUND_SECS
//   tick      - one-second decrement enable (already qualified by the caller)
//   freeze    - suppress the decrement this cycle
//   secs_left - remaining seconds
//   expire    - tick arriving while one second remains
module round_timer #(
   parameter int unsigned ROUND_SECS = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       tick,
   input  logic       freeze,
   output logic [6:0] secs_left,
   output logic       expire
);

   logic [6:0] secs_d, secs_q;

   always_comb begin
      secs_d = secs_q;
      if (load) begin
         secs_d = 7'(ROUND_SECS);
      end else if (tick && !freeze && (secs_q != 7'd0)) begin
         secs_d = secs_q - 7'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         secs_q <= '0;
      end else begin
         secs_q <= secs_d;
      end
   end

   assign secs_left = secs_q;
   assign expire    = tick && (secs_q == 7'd1);

endmodule

// File: rtl/score_round_ctrl.sv
// score_round_ctrl: runs one timed round per logged-in player, counts correct answers,
// requests scoring at round end, retries unanswered requests and latches the verdicts.
// Optional build macro SCORE_PENALTY_EN: wrong answers decrement the score (floor 0).
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   tick_1s             - one-second pulse
//   login_id            - logged-in player (0 = nobody)
//   round_start, quit   - round control pulses
//   ans_valid/correct   - answer pulse and its verdict
//   result_ack          - clears the result
//   valid, pwinner, gwinner - scoring response
//   score_request, playerID, score - scoring request (playerID/score held until response)
//   cur_score, secs_left - live round status
//   busy, result_valid, result_pbest, result_gbest, result_err - status flags
module score_round_ctrl
   import score_pkg::*;
#(
   parameter int unsigned ROUND_SECS   = 60,
   parameter int unsigned RESP_TIMEOUT = 200,
   parameter int unsigned MAX_RETRY    = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_1s,
   input  logic [ID_W-1:0]    login_id,
   input  logic               round_start,
   input  logic               quit,
   input  logic               ans_valid,
   input  logic               ans_correct,
   input  logic               result_ack,
   input  logic               valid,
   input  logic               pwinner,
   input  logic [ID_W-1:0]    gwinner,
   output logic               score_request,
   output logic [ID_W-1:0]    playerID,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] cur_score,
   output logic [6:0]         secs_left,
   output logic               busy,
   output logic               result_valid,
   output logic               result_pbest,
   output logic               result_gbest,
   output logic               result_err
);

   localparam int unsigned TMO_W = $clog2(RESP_TIMEOUT + 1);
   localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);
   // Counter holds cycles elapsed since the request pulse; the next pulse lands exactly
   // RESP_TIMEOUT cycles after the previous one.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TIMEOUT - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

   state_e             state_d, state_q;
   logic [ID_W-1:0]    player_id_d, player_id_q;
   logic [SCORE_W-1:0] score_d, score_q;
   logic [SCORE_W-1:0] cur_score_d, cur_score_q;
   logic               score_req_d, score_req_q;
   logic               busy_d, busy_q;
   logic               rvalid_d, rvalid_q;
   logic               pbest_d, pbest_q;
   logic               gbest_d, gbest_q;
   logic               err_d, err_q;
   logic [TMO_W-1:0]   tmo_d, tmo_q;
   logic [RTY_W-1:0]   retry_d, retry_q;

   logic start_ok, timer_load, timer_tick, timer_expire;

   assign start_ok   = round_start && (login_id != '0);
   assign timer_load = start_ok && ((state_q == IDLE) || (state_q == RESULT));
   assign timer_tick = (state_q == PLAY) && tick_1s;

   round_timer #(
      .ROUND_SECS (ROUND_SECS)
   ) u_round_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (timer_load),
      .tick      (timer_tick),
      .freeze    (quit),
      .secs_left (secs_left),
      .expire    (timer_expire)
   );

   always_comb begin
      state_d     = state_q;
      player_id_d = player_id_q;
      score_d     = score_q;
      cur_score_d = cur_score_q;
      score_req_d = 1'b0;
      pbest_d     = pbest_q;
      gbest_d     = gbest_q;
      err_d       = err_q;
      tmo_d       = tmo_q;
      retry_d     = retry_q;

      unique case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d     = PLAY;
               player_id_d = login_id;
               cur_score_d = '0;
            end
         end
         PLAY: begin
            if (ans_valid && ans_correct) begin
               cur_score_d = sat_inc(cur_score_q);
`ifdef SCORE_PENALTY_EN
            end else if (ans_valid && (cur_score_q != '0)) begin
               cur_score_d = cur_score_q - 1'b1;
`endif
            end
            // Last answer of the round is folded in before the score is captured.
            if (quit || timer_expire) begin
               state_d     = REQ;
               score_d     = cur_score_d;
               score_req_d = 1'b1;
               retry_d     = '0;
            end
         end
         REQ: begin
            state_d = WAIT_RESP;
            tmo_d   = TMO_W'(1);
         end
         WAIT_RESP: begin
            if (valid) begin
               state_d = RESULT;
               pbest_d = pwinner;
               gbest_d = (gwinner == player_id_q);
            end else if (tmo_q == TMO_LAST) begin
               if (retry_q < RTY_MAX) begin
                  state_d     = REQ;
                  score_req_d = 1'b1;
                  retry_d     = retry_q + 1'b1;
               end else begin
                  state_d = RESULT;
                  err_d   = 1'b1;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         RESULT: begin
            if (start_ok) begin
               state_d     = PLAY;
               player_id_d = login_id;
               cur_score_d = '0;
               pbest_d     = 1'b0;
               gbest_d     = 1'b0;
               err_d       = 1'b0;
            end else if (result_ack) begin
               state_d = IDLE;
               pbest_d = 1'b0;
               gbest_d = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d   = (state_d == PLAY) || (state_d == REQ) || (state_d == WAIT_RESP);
      rvalid_d = (state_d == RESULT);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         player_id_q <= '0;
         score_q     <= '0;
         cur_score_q <= '0;
         score_req_q <= 1'b0;
         busy_q      <= 1'b0;
         rvalid_q    <= 1'b0;
         pbest_q     <= 1'b0;
         gbest_q     <= 1'b0;
         err_q       <= 1'b0;
         tmo_q       <= '0;
         retry_q     <= '0;
      end else begin
         state_q     <= state_d;
         player_id_q <= player_id_d;
         score_q     <= score_d;
         cur_score_q <= cur_score_d;
         score_req_q <= score_req_d;
         busy_q      <= busy_d;
         rvalid_q    <= rvalid_d;
         pbest_q     <= pbest_d;
         gbest_q     <= gbest_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
         retry_q     <= retry_d;
      end
   end

   assign score_request = score_req_q;
   assign playerID      = player_id_q;
   assign score         = score_q;
   assign cur_score     = cur_score_q;
   assign busy          = busy_q;
   assign result_valid  = rvalid_q;
   assign result_pbest  = pbest_q;
   assign result_gbest  = gbest_q;
   assign result_err    = err_q;

endmodule

// File: tb/tb_score_round_ctrl.sv
// tb_score_round_ctrl: directed-vector bench for score_round_ctrl with hand-computed
// expected values. Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_score_round_ctrl;

   logic       clk;
   logic       rst;
   logic       tick_1s;
   logic [4:0] login_id;
   logic       round_start;
   logic       quit;
   logic       ans_valid;
   logic       ans_correct;
   logic       result_ack;
   logic       valid;
   logic       pwinner;
   logic [4:0] gwinner;
   logic       score_request;
   logic [4:0] playerID;
   logic [6:0] score;
   logic [6:0] cur_score;
   logic [6:0] secs_left;
   logic       busy;
   logic       result_valid;
   logic       result_pbest;
   logic       result_gbest;
   logic       result_err;

   int n_vec = 0;
   int n_err = 0;
   int cyc;

   score_round_ctrl u_dut (
      .clk           (clk),
      .rst           (rst),
      .tick_1s       (tick_1s),
      .login_id      (login_id),
      .round_start   (round_start),
      .quit          (quit),
      .ans_valid     (ans_valid),
      .ans_correct   (ans_correct),
      .result_ack    (result_ack),
      .valid         (valid),
      .pwinner       (pwinner),
      .gwinner       (gwinner),
      .score_request (score_request),
      .playerID      (playerID),
      .score         (score),
      .cur_score     (cur_score),
      .secs_left     (secs_left),
      .busy          (busy),
      .result_valid  (result_valid),
      .result_pbest  (result_pbest),
      .result_gbest  (result_gbest),
      .result_err    (result_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until the next score_request pulse; returns cycles taken (bounded).
   task automatic wait_pulse(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!score_request && n < 1000);
   endtask

   task automatic start_round(input logic [4:0] id);
      login_id    = id;
      round_start = 1'b1;
      step();
      round_start = 1'b0;
   endtask

   task automatic respond(input logic pw, input logic [4:0] gw);
      valid   = 1'b1;
      pwinner = pw;
      gwinner = gw;
      step();
      valid   = 1'b0;
      pwinner = 1'b0;
      gwinner = '0;
   endtask

   task automatic ack();
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b0; tick_1s = 0; login_id = '0; round_start = 0; quit = 0;
      ans_valid = 0; ans_correct = 0; result_ack = 0; valid = 0; pwinner = 0; gwinner = '0;
      #1;
      step(); step();
      check("rst_busy", busy, 0);
      check("rst_rvalid", result_valid, 0);
      check("rst_req", score_request, 0);
      check("rst_secs", secs_left, 0);
      check("rst_cur", cur_score, 0);
      rst = 1'b1;
      step();

      // 1: full round, 3 correct + 1 wrong, 60 ticks, winner response
      start_round(5'd5);
      check("t1_busy", busy, 1);
      check("t1_secs", secs_left, 60);
      check("t1_pid", playerID, 5);
      ans_valid = 1; ans_correct = 1;
      step(); step(); step();
      ans_correct = 0;
      step();
      ans_valid = 0;
`ifdef SCORE_PENALTY_EN
      check("t1_cur", cur_score, 2);
`else
      check("t1_cur", cur_score, 3);
`endif
      tick_1s = 1;
      for (int i = 0; i < 59; i++) step();
      check("t1_secs1", secs_left, 1);
      check("t1_noreq", score_request, 0);
      step();
      tick_1s = 0;
      check("t1_req", score_request, 1);
`ifdef SCORE_PENALTY_EN
      check("t1_score", score, 2);
`else
      check("t1_score", score, 3);
`endif
      check("t1_secs0", secs_left, 0);
      step();
      check("t1_req_once", score_request, 0);
      step();
      respond(1'b1, 5'd5);
      check("t1_rvalid", result_valid, 1);
      check("t1_pbest", result_pbest, 1);
      check("t1_gbest", result_gbest, 1);
      check("t1_busy_res", busy, 0);
      ack();
      check("t1_ack_rvalid", result_valid, 0);
      check("t1_ack_pbest", result_pbest, 0);

      // 2: guest, no response -> 4 pulses RESP_TIMEOUT apart, then error
      start_round(5'd3);
      quit = 1;
      step();
      quit = 0;
      check("t2_req0", score_request, 1);
      check("t2_guest_pid", playerID, 3);
      for (int r = 0; r < 3; r++) begin
         wait_pulse(cyc);
         check("t2_retry_gap", cyc, 200);
         check("t2_pid_hold", playerID, 3);
      end
      for (int i = 0; i < 199; i++) step();
      check("t2_not_yet", result_valid, 0);
      check("t2_no5th", score_request, 0);
      step();
      check("t2_err", result_err, 1);
      check("t2_rvalid", result_valid, 1);
      check("t2_req_after", score_request, 0);
      ack();
      check("t2_err_clr", result_err, 0);

      // 3: saturation at 99
      start_round(5'd7);
      ans_valid = 1; ans_correct = 1;
      for (int i = 0; i < 98; i++) step();
      check("t3_cur98", cur_score, 98);
      for (int i = 0; i < 7; i++) step();
      ans_valid = 0; ans_correct = 0;
      check("t3_cur99", cur_score, 99);
      quit = 1;
      step();
      quit = 0;
      check("t3_req", score_request, 1);
      check("t3_score", score, 99);
      step();
      respond(1'b0, 5'd2);
      check("t3_pbest", result_pbest, 0);
      check("t3_gbest", result_gbest, 0);
      ack();

      // 4: quit at 50 s with the 7th correct answer in the same cycle
      start_round(5'd4);
      tick_1s = 1;
      for (int i = 0; i < 10; i++) step();
      tick_1s = 0;
      check("t4_secs50", secs_left, 50);
      ans_valid = 1; ans_correct = 1;
      for (int i = 0; i < 6; i++) step();
      quit = 1; tick_1s = 1;
      step();
      quit = 0; tick_1s = 0; ans_valid = 0; ans_correct = 0;
      check("t4_req", score_request, 1);
      check("t4_score", score, 7);
      check("t4_secs_frozen", secs_left, 50);
      step();
      check("t4_secs_hold", secs_left, 50);
      respond(1'b0, 5'd4);
      check("t4_pbest", result_pbest, 0);
      check("t4_gbest", result_gbest, 1);
      ack();

      // 5: ignored starts
      start_round(5'd0);
      check("t5_idle_busy", busy, 0);
      check("t5_idle_secs", secs_left, 50);
      start_round(5'd6);
      tick_1s = 1;
      step(); step(); step();
      tick_1s = 0;
      ans_valid = 1; ans_correct = 1;
      step(); step();
      ans_valid = 0; ans_correct = 0;
      start_round(5'd8);
      check("t5_cur", cur_score, 2);
      check("t5_secs", secs_left, 57);
      check("t5_pid", playerID, 6);

      // 6: reset while waiting for the response, then a late valid
      quit = 1;
      step();
      quit = 0;
      step();
      check("t6_busy_wait", busy, 1);
      rst = 0;
      step();
      rst = 1;
      check("t6_busy", busy, 0);
      check("t6_pid", playerID, 0);
      check("t6_score", score, 0);
      check("t6_cur", cur_score, 0);
      check("t6_secs", secs_left, 0);
      respond(1'b1, 5'd6);
      check("t6_late_rvalid", result_valid, 0);
      check("t6_late_pbest", result_pbest, 0);
      check("t6_late_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
